// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the RV32M multiply/divide unit.
//   RV_XLEN         : default operand/result width
//   OPCODE_OP       : major opcode of register-register ALU ops
//   FUNCT7_MULDIV   : funct7 selecting the M extension inside OPCODE_OP
//   MULDIV_*        : funct3 encodings of the eight M-extension ops
//   muldiv_state_e  : control state of the iterative unit
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int RV_XLEN = 32;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // rs1 is interpreted as two's complement for these ops
    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return (f3 == MULDIV_MULH) || (f3 == MULDIV_MULHSU) ||
               (f3 == MULDIV_DIV)  || (f3 == MULDIV_REM);
    endfunction

    // rs2 is interpreted as two's complement for these ops
    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 == MULDIV_MULH) || (f3 == MULDIV_DIV) || (f3 == MULDIV_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
// Request/response bundle between the EX stage and the multiply/divide unit.
//   start  : request (master -> slave)
//   kill   : pipeline flush, aborts the operation (master -> slave)
//   funct3 : RV32M operation select (master -> slave)
//   rs1    : operand A, dividend/multiplicand (master -> slave)
//   rs2    : operand B, divisor/multiplier (master -> slave)
//   busy   : operation in progress, stalls IF/ID/EX (slave -> master)
//   ready  : one-cycle result-valid pulse (slave -> master)
//   result : held result register (slave -> master)
// ---------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int XLEN = cpu_pkg::RV_XLEN
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            ready;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, funct3, rs1, rs2,
        input  busy, ready, result
    );

    modport slave (
        input  start, kill, funct3, rs1, rs2,
        output busy, ready, result
    );
endinterface

// File: rtl/muldiv_divstep.sv
// ---------------------------------------------------------------------------
// muldiv_divstep
// One combinational restoring-division step on unsigned magnitudes.
//   rem      : current partial remainder (always < divisor)
//   dvd_msb  : next dividend bit shifted into the remainder
//   divisor  : unsigned divisor (non-zero)
//   rem_next : partial remainder after the trial subtraction
//   q_bit    : quotient bit produced by this step
// ---------------------------------------------------------------------------
module muldiv_divstep #(
    parameter int XLEN = cpu_pkg::RV_XLEN
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);
    // The shifted remainder can reach 2*divisor-1, so it needs one extra bit.
    logic [XLEN:0] partial;

    assign partial = {rem, dvd_msb};
    assign q_bit   = (partial >= {1'b0, divisor});
    // When the subtraction succeeds the difference is < divisor, so the
    // modulo-2^XLEN subtraction on the low bits is exact.
    assign rem_next = q_bit ? (partial[XLEN-1:0] - divisor) : partial[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiply: sign-magnitude shift-add, one multiplier bit per cycle.
// Divide  : restoring division on magnitudes, one quotient bit per cycle.
// Divide-by-zero and signed overflow finish in one cycle without CALC.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : muldiv_unit_if.slave (start/kill/funct3/rs1/rs2 in,
//         busy/ready/result out)
// Build option:
//   MULDIV_FAST_MUL_EN : when defined, multiplies use a single-cycle
//                        2*XLEN product and skip CALC; divides unchanged.
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN  = cpu_pkg::RV_XLEN,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_unit_if.slave   bus
);
    import cpu_pkg::*;

    // Control
    muldiv_state_e    state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             ready_q;
    logic [XLEN-1:0]  result_q;

    // Datapath (captured at start, no reset needed)
    logic [2:0]        op;
    logic              neg_q;      // negate product / quotient
    logic              neg_r;      // negate remainder
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplr;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   dvd;
    logic [XLEN-1:0]   dsr;

    // Operand decode at the request
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, div_ovf, div_special;
    logic [XLEN-1:0] special_res;
    logic            accept;

    assign a_neg = rs1_is_signed(bus.funct3) & bus.rs1[XLEN-1];
    assign b_neg = rs2_is_signed(bus.funct3) & bus.rs2[XLEN-1];
    assign a_abs = a_neg ? -bus.rs1 : bus.rs1;
    assign b_abs = b_neg ? -bus.rs2 : bus.rs2;

    assign div_zero = bus.funct3[2] && (bus.rs2 == '0);
    assign div_ovf  = bus.funct3[2] && rs1_is_signed(bus.funct3) &&
                      (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
    assign div_special = div_zero || div_ovf;
    // funct3[1] selects remainder among the divide ops
    assign special_res = div_zero ? (bus.funct3[1] ? bus.rs1 : '1)
                                  : (bus.funct3[1] ? '0 : bus.rs1);

    assign accept = (state == IDLE) && bus.start && !bus.kill;

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extending to 2*XLEN makes an unsigned multiply yield the
    // correct signed/unsigned product in the low 2*XLEN bits.
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]   fast_res;

    assign fast_a    = {{XLEN{a_neg}}, bus.rs1};
    assign fast_b    = {{XLEN{b_neg}}, bus.rs2};
    assign fast_prod = fast_a * fast_b;
    assign fast_res  = (bus.funct3 == MULDIV_MUL) ? fast_prod[XLEN-1:0]
                                                  : fast_prod[2*XLEN-1:XLEN];
`endif

    // Per-cycle iteration
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   dvd_step;
    logic              q_step;

    assign acc_step = acc + (mplr[0] ? mcand : '0);

    muldiv_divstep #(.XLEN(XLEN)) u_divstep (
        .rem      (rem),
        .dvd_msb  (dvd[XLEN-1]),
        .divisor  (dsr),
        .rem_next (rem_step),
        .q_bit    (q_step)
    );

    // Quotient bits enter at the LSB as dividend bits leave at the MSB.
    assign dvd_step = {dvd[XLEN-2:0], q_step};

    // Final result, valid on the last CALC cycle
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, calc_res;

    assign prod = neg_q ? -acc_step : acc_step;
    assign quo  = neg_q ? -dvd_step : dvd_step;
    assign rmd  = neg_r ? -rem_step : rem_step;

    always_comb begin
        calc_res = '0;
        if (op[2])
            calc_res = op[1] ? rmd : quo;
        else if (op == MULDIV_MUL)
            calc_res = prod[XLEN-1:0];
        else
            calc_res = prod[2*XLEN-1:XLEN];
    end

    // Control FSM: busy/ready are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else if (bus.kill) begin
            state   <= IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (bus.start) begin
                        cnt <= CNT_W'(XLEN);
                        if (div_special) begin
                            result_q <= special_res;
                            ready_q  <= 1'b1;
                            state    <= DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!bus.funct3[2]) begin
                            result_q <= fast_res;
                            ready_q  <= 1'b1;
                            state    <= DONE;
                        end
`endif
                        else begin
                            busy_q <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result_q <= calc_res;
                        busy_q   <= 1'b0;
                        ready_q  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Datapath: load magnitudes on accept, shift one step per CALC cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            op    <= bus.funct3;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            acc   <= '0;
            mcand <= {{XLEN{1'b0}}, a_abs};
            mplr  <= b_abs;
            rem   <= '0;
            dvd   <= a_abs;
            dsr   <= b_abs;
        end else if (state == CALC) begin
            acc   <= acc_step;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            rem   <= rem_step;
            dvd   <= dvd_step;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.ready  = ready_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: directed vector table, randomized
// operations against an arithmetic reference model, and hand-written
// sequences for ignored starts, kill and reset during an operation.
// Honors MULDIV_FAST_MUL_EN for the expected multiply latency.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
    import cpu_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model straight from the RV32M definitions
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        sa = a;
        sb = b;
        ea = rs1_is_signed(f3) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = rs2_is_signed(f3) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        case (f3)
            MULDIV_MUL:    return p[31:0];
            MULDIV_MULH,
            MULDIV_MULHSU,
            MULDIV_MULHU:  return p[63:32];
            MULDIV_DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return sa / sb;
            end
            MULDIV_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
            MULDIV_REM: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return sa % sb;
            end
            default:       return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycle (relative to the sampling edge) in which ready is expected
    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == MULDIV_DIV || f3 == MULDIV_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF)
            return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    // Issue one op, scramble the operand inputs afterwards, and watch the
    // response. Returns in the cycle after ready (back in IDLE).
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int rdy_at, output int busy_cnt,
                         output logic ready_after);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f3; bus.rs1 = a; bus.rs2 = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.rs1 = $urandom; bus.rs2 = $urandom; bus.funct3 = 3'($urandom);
        rdy_at = -1; busy_cnt = 0; res = 'x; ready_after = 1'bx;
        for (int k = 1; k <= XLEN + 8; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.ready) begin
                rdy_at = k;
                res = bus.result;
                break;
            end
            @(posedge clk); #1;
        end
        if (rdy_at > 0) begin
            @(posedge clk); #1;
            ready_after = bus.ready;
        end
    endtask

    task automatic run_checked(input string name, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] res;
        int rdy_at, busy_cnt, lat;
        logic ready_after;
        lat = exp_lat(f3, a, b);
        do_op(f3, a, b, res, rdy_at, busy_cnt, ready_after);
        chk({name, "_result"}, res, exp);
        chk({name, "_ready_cycle"}, rdy_at, lat);
        chk({name, "_busy_cycles"}, busy_cnt, lat - 1);
        if (rdy_at > 0) begin
            chk({name, "_ready_pulse"}, {31'b0, ready_after}, 32'h0);
            chk({name, "_held"}, bus.result, exp);
        end
    endtask

    vec_t vecs[14];

    initial begin
        logic [31:0] res, a, b;
        logic [2:0]  f3;
        logic [31:0] seq_a, seq_b, seq_exp;
        logic [2:0]  seq_f3;
        int rdy_at, busy_cnt, lat, ready_seen;
        logic ready_after;

        vecs[0]  = '{"mul_6x4",      MULDIV_MUL,    32'd6,        32'd4,        32'h00000018};
        vecs[1]  = '{"mulh_min",     MULDIV_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
        vecs[2]  = '{"mulhu_max",    MULDIV_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[3]  = '{"mulhsu_m1x2",  MULDIV_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        vecs[4]  = '{"div_m7_2",     MULDIV_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        vecs[5]  = '{"rem_m7_2",     MULDIV_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vecs[6]  = '{"divu_100_7",   MULDIV_DIVU,   32'd100,      32'd7,        32'd14};
        vecs[7]  = '{"remu_100_7",   MULDIV_REMU,   32'd100,      32'd7,        32'd2};
        vecs[8]  = '{"divu_5_0",     MULDIV_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF};
        vecs[9]  = '{"rem_5_0",      MULDIV_REM,    32'd5,        32'd0,        32'd5};
        vecs[10] = '{"div_ovf",      MULDIV_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{"rem_ovf",      MULDIV_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0};
        vecs[12] = '{"mul_neg",      MULDIV_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1};
        vecs[13] = '{"div_7_m2",     MULDIV_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};

        rst = 1'b1;
        bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = '0; bus.rs1 = '0; bus.rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   {31'b0, bus.busy},  32'h0);
        chk("reset_ready",  {31'b0, bus.ready}, 32'h0);
        chk("reset_result", bus.result,         32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 14; i++)
            run_checked(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Randomized ops against the reference model, biased to corners
        for (int i = 0; i < 80; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 255);
                default: ;
            endcase
            lat = exp_lat(f3, a, b);
            do_op(f3, a, b, res, rdy_at, busy_cnt, ready_after);
            chk($sformatf("rand%0d_f%0d_result", i, f3), res, ref_model(f3, a, b));
            chk($sformatf("rand%0d_ready_cycle", i), rdy_at, lat);
        end

        // Start during CALC and during DONE must be ignored
`ifdef MULDIV_FAST_MUL_EN
        seq_f3 = MULDIV_DIVU; seq_a = 32'd45; seq_b = 32'd3; seq_exp = 32'd15;
`else
        seq_f3 = MULDIV_MUL;  seq_a = 32'd3;  seq_b = 32'd5; seq_exp = 32'd15;
`endif
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = seq_f3; bus.rs1 = seq_a; bus.rs2 = seq_b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        rdy_at = -1;
        for (int k = 1; k <= XLEN + 6; k++) begin
            if (bus.ready && rdy_at < 0) rdy_at = k;
            if (rdy_at > 0 && (k == rdy_at + 1 || k == rdy_at + 2)) begin
                chk($sformatf("ignore_done_busy_k%0d", k - rdy_at), {31'b0, bus.busy}, 32'h0);
                chk($sformatf("ignore_done_ready_k%0d", k - rdy_at), {31'b0, bus.ready}, 32'h0);
            end
            bus.start = 1'b0;
            if (k == 10 || k == rdy_at) begin
                bus.start = 1'b1; bus.funct3 = seq_f3; bus.rs1 = 32'd9; bus.rs2 = 32'd9;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk("ignore_ready_cycle", rdy_at, XLEN + 1);
        chk("ignore_result", bus.result, seq_exp);
        run_checked("after_ignore_9x9", MULDIV_MUL, 32'd9, 32'd9, 32'd81);

        // Kill mid-divide: back to IDLE, no ready, result kept
        run_checked("pre_kill_divu", MULDIV_DIVU, 32'd100, 32'd7, 32'd14);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = MULDIV_DIV; bus.rs1 = 32'h12345678; bus.rs2 = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ready_seen = 0;
        for (int k = 1; k <= XLEN + 8; k++) begin
            if (bus.ready) ready_seen = 1;
            if (k == 11) chk("kill_busy_before", {31'b0, bus.busy}, 32'h1);
            if (k == 13) chk("kill_idle_busy", {31'b0, bus.busy}, 32'h0);
            bus.kill = (k == 12);
            @(posedge clk); #1;
        end
        bus.kill = 1'b0;
        chk("kill_no_ready", ready_seen, 0);
        chk("kill_result_kept", bus.result, 32'd14);

        // Kill and start together in IDLE: start dropped
        @(negedge clk);
        bus.start = 1'b1; bus.kill = 1'b1; bus.funct3 = MULDIV_DIVU; bus.rs1 = 32'd5; bus.rs2 = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.kill = 1'b0;
        ready_seen = 0;
        for (int k = 1; k <= 4; k++) begin
            if (bus.ready || bus.busy) ready_seen = 1;
            @(posedge clk); #1;
        end
        chk("kill_start_dropped", ready_seen, 0);
        chk("kill_start_result", bus.result, 32'd14);

        // Reset mid-operation: aborts, clears result, no ready
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = MULDIV_DIV; bus.rs1 = 32'd1000; bus.rs2 = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ready_seen = 0;
        for (int k = 1; k <= XLEN + 8; k++) begin
            if (bus.ready) ready_seen = 1;
            if (k == 13) begin
                chk("rst_busy",   {31'b0, bus.busy}, 32'h0);
                chk("rst_result", bus.result,        32'h0);
            end
            rst = (k == 12);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        chk("rst_no_ready", ready_seen, 0);
        run_checked("after_rst_mul", MULDIV_MUL, 32'd2, 32'd3, 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
